// File: rtl/ac97_cmd_sched.sv
// AC97 command-slot scheduler: shares slots 1/2 between two requesters, one grant per frame tick.
// Optional AC97_CMD_FIXED_PRI_EN selects fixed priority (req0 first) instead of round-robin.
module ac97_cmd_sched #(
  parameter int unsigned HOLD_FRAMES = 2,
  parameter logic [7:0]  IDLE_ADDR   = 8'h80
) (
  input  logic        system_clock,
  input  logic        reset,
  input  logic        ready,
  input  logic        req0_valid,
  input  logic [7:0]  req0_addr,
  input  logic [15:0] req0_data,
  input  logic        req1_valid,
  input  logic [7:0]  req1_addr,
  input  logic [15:0] req1_data,
  output logic        req0_ack,
  output logic        req1_ack,
  output logic [7:0]  command_address,
  output logic [15:0] command_data,
  output logic        command_valid,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_FRAMES - 1);

  state_t      state, state_nxt;
  logic [2:0]  rdy_sync;
  logic        frame_tick;
  logic [3:0]  hold_cnt;
  logic        arb;
  logic        win_vld;
  logic        win_id;
  logic [7:0]  win_addr;
  logic [15:0] win_data;
`ifndef AC97_CMD_FIXED_PRI_EN
  logic        last_grant;
`endif

  // [0],[1] synchronize ready; [2] is the previous value for edge detect
  always_ff @(posedge system_clock) begin
    if (reset) begin
      rdy_sync   <= '0;
      frame_tick <= 1'b0;
    end else begin
      rdy_sync   <= {rdy_sync[1:0], ready};
      frame_tick <= rdy_sync[1] & ~rdy_sync[2];
    end
  end

  always_comb begin
    win_vld = req0_valid | req1_valid;
`ifdef AC97_CMD_FIXED_PRI_EN
    win_id  = ~req0_valid;
`else
    if (req0_valid && req1_valid) win_id = ~last_grant;
    else                          win_id = ~req0_valid;
`endif
    win_addr = win_id ? req1_addr : req0_addr;
    win_data = win_id ? req1_data : req0_data;
  end

  assign arb = frame_tick && (state == S_IDLE || hold_cnt == 4'd0);

  always_ff @(posedge system_clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (arb) state_nxt = win_vld ? S_HOLD : S_IDLE;
  end

  always_comb begin
    busy = (state == S_HOLD);
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      command_address <= IDLE_ADDR;
      command_data    <= 16'h0000;
      command_valid   <= 1'b0;
      req0_ack        <= 1'b0;
      req1_ack        <= 1'b0;
      grant_id        <= 1'b0;
      hold_cnt        <= 4'd0;
`ifndef AC97_CMD_FIXED_PRI_EN
      last_grant      <= 1'b1;
`endif
    end else begin
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
      if (arb) begin
        command_valid <= 1'b1;
        if (win_vld) begin
          command_address <= win_addr;
          command_data    <= win_data;
          req0_ack        <= ~win_id;
          req1_ack        <= win_id;
          grant_id        <= win_id;
          hold_cnt        <= HOLD_LOAD;
`ifndef AC97_CMD_FIXED_PRI_EN
          last_grant      <= win_id;
`endif
        end else begin
          command_address <= IDLE_ADDR;
          command_data    <= 16'h0000;
        end
      end else if (frame_tick && state == S_HOLD) begin
        hold_cnt <= hold_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_ac97_cmd_sched.sv
// Directed bench for ac97_cmd_sched: frame ticks are produced by pulsing ready by hand.
module tb_ac97_cmd_sched;
  logic        clk = 1'b0;
  logic        reset, ready;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_addr, req1_addr;
  logic [15:0] req0_data, req1_data;
  logic        req0_ack, req1_ack, command_valid, busy, grant_id;
  logic [7:0]  command_address;
  logic [15:0] command_data;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ack0  = 0;
  int n_ack1  = 0;

  // snapshots: pre = edge k+2, s = edge k+3, post = edge k+4
  logic [7:0]  pre_addr, s_addr;
  logic [15:0] s_data;
  logic        pre_valid, pre_a0, pre_a1;
  logic        s_valid, s_a0, s_a1, s_busy, s_gid, post_a0, post_a1;

  ac97_cmd_sched dut (
    .system_clock(clk), .reset(reset), .ready(ready),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req0_ack(req0_ack), .req1_ack(req1_ack),
    .command_address(command_address), .command_data(command_data),
    .command_valid(command_valid), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (req0_ack) n_ack0++;
    if (req1_ack) n_ack1++;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk);
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pre_addr = command_address; pre_valid = command_valid;
    pre_a0 = req0_ack; pre_a1 = req1_ack;
    @(posedge clk);
    #1;
    s_addr = command_address; s_data = command_data; s_valid = command_valid;
    s_a0 = req0_ack; s_a1 = req1_ack; s_busy = busy; s_gid = grant_id;
    @(posedge clk);
    #1;
    post_a0 = req0_ack; post_a1 = req1_ack;
    repeat (3) @(negedge clk);
    ready = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++; if (command_address !== 8'h80) begin n_fail++; $display("FAIL reset_addr: got %h want 80", command_address); end
    n_tests++; if (command_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", command_data); end
    n_tests++; if ({command_valid, req0_ack, req1_ack, busy, grant_id} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got v/a0/a1/busy/gid=%b want 00000", {command_valid, req0_ack, req1_ack, busy, grant_id}); end
  endtask

  task automatic test_single_write();
    int b0;
    do_reset();
    b0 = n_ack0;
    req0_valid = 1'b1; req0_addr = 8'h02; req0_data = 16'h0808;
    frame();
    n_tests++; if ({pre_valid, pre_a0} !== 2'b00 || pre_addr !== 8'h80) begin n_fail++; $display("FAIL single_latency: got v/a0=%b addr=%h at k+2 want 00/80", {pre_valid, pre_a0}, pre_addr); end
    n_tests++; if (s_addr !== 8'h02 || s_data !== 16'h0808 || s_valid !== 1'b1) begin n_fail++; $display("FAIL single_cmd: got %h/%h/%b want 02/0808/1", s_addr, s_data, s_valid); end
    n_tests++; if ({s_a0, s_a1, post_a0, s_busy, s_gid} !== 5'b10010) begin n_fail++; $display("FAIL single_ack: got a0/a1/a0next/busy/gid=%b want 10010", {s_a0, s_a1, post_a0, s_busy, s_gid}); end
    req0_valid = 1'b0;
    frame();
    n_tests++; if (s_addr !== 8'h02 || s_busy !== 1'b1 || s_a0 !== 1'b0) begin n_fail++; $display("FAIL single_hold: got addr=%h busy=%b a0=%b want 02/1/0", s_addr, s_busy, s_a0); end
    frame();
    n_tests++; if (s_addr !== 8'h80 || s_data !== 16'h0000 || s_valid !== 1'b1 || s_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %h/%h/%b busy=%b want 80/0000/1/0", s_addr, s_data, s_valid, s_busy); end
    n_tests++; if (n_ack0 - b0 !== 1) begin n_fail++; $display("FAIL single_ack_count: got %0d want 1", n_ack0 - b0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req0_valid = 1'b1; req0_addr = 8'h02; req0_data = 16'h0808;
    req1_valid = 1'b1; req1_addr = 8'h04; req1_data = 16'h0909;
    frame();
    n_tests++; if (s_a0 !== 1'b1 || s_a1 !== 1'b0 || s_addr !== 8'h02 || s_gid !== 1'b0) begin n_fail++; $display("FAIL b2b_tick1: got a0=%b a1=%b addr=%h gid=%b want 1/0/02/0", s_a0, s_a1, s_addr, s_gid); end
`ifdef AC97_CMD_FIXED_PRI_EN
    frame();
    frame();
    n_tests++; if (s_a0 !== 1'b1 || s_a1 !== 1'b0 || s_addr !== 8'h02 || s_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_fixed_tick3: got a0=%b a1=%b addr=%h busy=%b want 1/0/02/1", s_a0, s_a1, s_addr, s_busy); end
    req0_valid = 1'b0;
    frame();
    frame();
    n_tests++; if (s_a1 !== 1'b1 || s_addr !== 8'h04 || s_data !== 16'h0909 || s_gid !== 1'b1) begin n_fail++; $display("FAIL b2b_fixed_tick5: got a1=%b addr=%h data=%h gid=%b want 1/04/0909/1", s_a1, s_addr, s_data, s_gid); end
    req1_valid = 1'b0;
    frame();
    frame();
    n_tests++; if (s_addr !== 8'h80 || s_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_fixed_idle: got addr=%h busy=%b want 80/0", s_addr, s_busy); end
`else
    req0_valid = 1'b0;
    frame();
    n_tests++; if (s_a1 !== 1'b0 || s_addr !== 8'h02 || s_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_tick2: got a1=%b addr=%h busy=%b want 0/02/1", s_a1, s_addr, s_busy); end
    frame();
    n_tests++; if (s_a1 !== 1'b1 || s_addr !== 8'h04 || s_data !== 16'h0909 || s_gid !== 1'b1 || s_busy !== 1'b1 || pre_addr !== 8'h02) begin n_fail++; $display("FAIL b2b_tick3: got a1=%b %h/%h gid=%b busy=%b prev=%h want 1 04/0909 1 1 02", s_a1, s_addr, s_data, s_gid, s_busy, pre_addr); end
    req1_valid = 1'b0;
    frame();
    frame();
    n_tests++; if (s_addr !== 8'h80 || s_busy !== 1'b0 || s_gid !== 1'b1) begin n_fail++; $display("FAIL b2b_tick5: got addr=%h busy=%b gid=%b want 80/0/1", s_addr, s_busy, s_gid); end
`endif
  endtask

  task automatic test_mid_hold();
    int b1;
    do_reset();
    b1 = n_ack1;
    req0_valid = 1'b1; req0_addr = 8'h02; req0_data = 16'h0808;
    frame();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 8'h06; req1_data = 16'h1234;
    frame();
    n_tests++; if (s_a1 !== 1'b0 || s_addr !== 8'h02 || n_ack1 - b1 !== 0) begin n_fail++; $display("FAIL mid_early: got a1=%b addr=%h acks=%0d want 0/02/0", s_a1, s_addr, n_ack1 - b1); end
    frame();
    n_tests++; if (pre_a1 !== 1'b0 || pre_addr !== 8'h02) begin n_fail++; $display("FAIL mid_k2: got a1=%b addr=%h want 0/02", pre_a1, pre_addr); end
    n_tests++; if (s_a1 !== 1'b1 || post_a1 !== 1'b0 || s_addr !== 8'h06 || s_data !== 16'h1234 || s_busy !== 1'b1 || s_gid !== 1'b1) begin n_fail++; $display("FAIL mid_grant: got a1=%b/%b %h/%h busy=%b gid=%b want 1/0 06/1234 1 1", s_a1, post_a1, s_addr, s_data, s_busy, s_gid); end
    req1_valid = 1'b0;
    frame();
    frame();
    n_tests++; if (s_addr !== 8'h80 || s_busy !== 1'b0 || n_ack1 - b1 !== 1) begin n_fail++; $display("FAIL mid_drain: got addr=%h busy=%b acks=%0d want 80/0/1", s_addr, s_busy, n_ack1 - b1); end
  endtask

  task automatic test_ready_stuck();
    int b0;
    do_reset();
    b0 = n_ack0;
    req0_valid = 1'b1; req0_addr = 8'h0a; req0_data = 16'h5555;
    @(negedge clk);
    ready = 1'b1;
    repeat (1000) @(negedge clk);
    n_tests++; if (n_ack0 - b0 !== 1 || command_address !== 8'h0a || busy !== 1'b1) begin n_fail++; $display("FAIL stuck_one: got acks=%0d addr=%h busy=%b want 1/0a/1", n_ack0 - b0, command_address, busy); end
    req0_valid = 1'b0;
    ready = 1'b0;
    repeat (8) @(negedge clk);
    frame();
    n_tests++; if (s_addr !== 8'h0a || s_busy !== 1'b1 || s_a0 !== 1'b0) begin n_fail++; $display("FAIL stuck_hold: got addr=%h busy=%b a0=%b want 0a/1/0", s_addr, s_busy, s_a0); end
    frame();
    n_tests++; if (s_addr !== 8'h80 || s_busy !== 1'b0) begin n_fail++; $display("FAIL stuck_release: got addr=%h busy=%b want 80/0", s_addr, s_busy); end
  endtask

  task automatic test_reset_mid_hold();
    int b0;
    do_reset();
    b0 = n_ack0;
    req0_valid = 1'b1; req0_addr = 8'h02; req0_data = 16'h0808;
    frame();
    req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_tests++; if (command_valid !== 1'b0 || busy !== 1'b0 || command_address !== 8'h80 || grant_id !== 1'b0) begin n_fail++; $display("FAIL rst_hold_out: got v=%b busy=%b addr=%h gid=%b want 0/0/80/0", command_valid, busy, command_address, grant_id); end
    @(negedge clk);
    reset = 1'b0;
    frame();
    n_tests++; if (s_valid !== 1'b1 || s_addr !== 8'h80 || s_data !== 16'h0000 || s_a0 !== 1'b0 || s_busy !== 1'b0) begin n_fail++; $display("FAIL rst_hold_tick: got v=%b %h/%h a0=%b busy=%b want 1 80/0000 0 0", s_valid, s_addr, s_data, s_a0, s_busy); end
    n_tests++; if (n_ack0 - b0 !== 1) begin n_fail++; $display("FAIL rst_hold_acks: got %0d want 1", n_ack0 - b0); end
  endtask

  task automatic test_drop_before_ack();
    int b0;
    b0 = n_ack0;
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 8'h12; req0_data = 16'hbeef;
    repeat (5) @(negedge clk);
    req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    frame();
    n_tests++; if (s_a0 !== 1'b0 || s_addr !== 8'h80 || s_valid !== 1'b1 || s_busy !== 1'b0 || n_ack0 - b0 !== 0) begin n_fail++; $display("FAIL drop: got a0=%b addr=%h v=%b busy=%b acks=%0d want 0/80/1/0/0", s_a0, s_addr, s_valid, s_busy, n_ack0 - b0); end
  endtask

  initial begin
    reset = 1'b1; ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = 8'h00; req1_addr = 8'h00;
    req0_data = 16'h0000; req1_data = 16'h0000;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_mid_hold();
    test_ready_stuck();
    test_reset_mid_hold();
    test_drop_before_ack();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
